// File: rtl/bn_stats_accum.sv
// Batch mean/variance producer for BatchNorm: sums x and x^2 over 2^LOG2_N samples.
// Optional macro BN_STATS_MIN_VAR_EN forces a zero variance result to 1.
module bn_stats_accum #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_N     = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+LOG2_N
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out_mean,
  output logic signed [DATA_WIDTH-1:0] out_variance,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int SUM_W = DATA_WIDTH + LOG2_N;
  localparam logic signed [ACC_WIDTH:0] VAR_MAX =
    {{(ACC_WIDTH+2-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {ACCUM, CALC_MEAN, CALC_VAR, HOLD} state_t;

  state_t                         state_q, state_d;
  logic        [LOG2_N-1:0]       count_q, count_d;
  logic signed [SUM_W-1:0]        sum_q, sum_d;
  logic        [ACC_WIDTH-1:0]    sumsq_q, sumsq_d;
  logic signed [DATA_WIDTH-1:0]   mean_q, mean_d;
  logic        [ACC_WIDTH-1:0]    msq_q, msq_d;
  logic signed [DATA_WIDTH-1:0]   out_mean_q, out_mean_d;
  logic signed [DATA_WIDTH-1:0]   out_var_q, out_var_d;
  logic                           out_valid_q, out_valid_d;

  logic signed [2*DATA_WIDTH-1:0] sample_sq;
  logic signed [SUM_W-1:0]        sample_ext;
  logic signed [SUM_W-1:0]        sum_shift;
  logic signed [2*DATA_WIDTH-1:0] mean_sq;
  logic signed [ACC_WIDTH:0]      diff;
  logic signed [DATA_WIDTH-1:0]   var_sat;

  assign sample_sq  = in_data * in_data;
  assign sample_ext = {{LOG2_N{in_data[DATA_WIDTH-1]}}, in_data};
  assign sum_shift  = sum_q >>> LOG2_N;
  assign mean_sq    = mean_q * mean_q;
  assign diff       = $signed({1'b0, msq_q})
                    - $signed({{(ACC_WIDTH+1-2*DATA_WIDTH){mean_sq[2*DATA_WIDTH-1]}}, mean_sq});

  // Clamp negative rounding artefacts to 0 and saturate to the signed output range.
  always_comb begin
    var_sat = '0;
    if (diff[ACC_WIDTH]) begin
      var_sat = '0;
    end else if (diff > VAR_MAX) begin
      var_sat = VAR_MAX[DATA_WIDTH-1:0];
    end else begin
      var_sat = diff[DATA_WIDTH-1:0];
    end
`ifdef BN_STATS_MIN_VAR_EN
    if (var_sat == '0) var_sat = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
`endif
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sum_d       = sum_q;
    sumsq_d     = sumsq_q;
    mean_d      = mean_q;
    msq_d       = msq_q;
    out_mean_d  = out_mean_q;
    out_var_d   = out_var_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ACCUM: begin
        if (in_valid) begin
          sum_d   = sum_q + sample_ext;
          sumsq_d = sumsq_q + {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, sample_sq};
          if (count_q == {LOG2_N{1'b1}}) begin
            count_d = '0;
            state_d = CALC_MEAN;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      CALC_MEAN: begin
        mean_d  = sum_shift[DATA_WIDTH-1:0];
        msq_d   = sumsq_q >> LOG2_N;
        state_d = CALC_VAR;
      end
      CALC_VAR: begin
        out_mean_d  = mean_q;
        out_var_d   = var_sat;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          sum_d       = '0;
          sumsq_d     = '0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ACCUM;
      count_q     <= '0;
      sum_q       <= '0;
      sumsq_q     <= '0;
      mean_q      <= '0;
      msq_q       <= '0;
      out_mean_q  <= '0;
      out_var_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      sumsq_q     <= sumsq_d;
      mean_q      <= mean_d;
      msq_q       <= msq_d;
      out_mean_q  <= out_mean_d;
      out_var_q   <= out_var_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Samples are taken only in ACCUM; the result is offered only in HOLD.
  assign in_ready     = (state_q == ACCUM);
  assign busy         = !((state_q == ACCUM) && (count_q == '0));
  assign out_mean     = out_mean_q;
  assign out_variance = out_var_q;
  assign out_valid    = out_valid_q;

endmodule

// File: doc/bn_stats_accum.md
Name: bn_stats_accum

Overview:
- Producer side of the serial BatchNorm parameter interface.
- Consumes a serial sample stream of one channel and accumulates sum and sum-of-squares over a fixed batch of N = 2^LOG2_N samples.
- Emits the batch mean and variance as the mean/variance operands for BatchNorm_param.
- Sits between the SE-layer activation stream and the BatchNorm parameter registers; a ready/valid handshake on both sides allows stalling.

Parameters:
- DATA_WIDTH, 16: signed sample width and output width.
- LOG2_N, 4: log2 of samples per batch (N = 16 by default); must be ≥ 1.
- ACC_WIDTH, 2*DATA_WIDTH+LOG2_N: sum-of-squares accumulator width. The sum accumulator is DATA_WIDTH+LOG2_N wide.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  DATA_WIDTH  signed sample.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- out_mean  out  DATA_WIDTH  signed batch mean.
- out_variance  out  DATA_WIDTH  signed batch variance, always ≥ 0.
- out_valid  out  1  mean/variance valid.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high in any state other than ACCUM with count = 0.

Behaviour:
- Reset (rst low, asynchronous): state ACCUM, count = 0, both accumulators = 0, out_mean = 0, out_variance = 0, out_valid = 0, in_ready = 1, busy = 0.
- Reset mid-batch discards partial sums; no result is emitted.
- States:
  - ACCUM: in_ready = 1. On each in_valid cycle: sum += in_data, sumsq += in_data², count++. When the accepted sample is sample N (count = N-1), go to CALC_MEAN and clear count.
  - CALC_MEAN: in_ready = 0. Register mean = sum >>> LOG2_N (arithmetic shift, floor toward −∞). Register msq = sumsq >> LOG2_N (floor). Go to CALC_VAR.
  - CALC_VAR: in_ready = 0. diff = msq − mean² (ACC_WIDTH+1 signed). If diff < 0, clamp to 0. If diff > 2^(DATA_WIDTH−1)−1, saturate to that value. Load out_mean and out_variance, set out_valid = 1, go to HOLD.
  - HOLD: in_ready = 0. out_valid, out_mean and out_variance are held stable. When out_valid && out_ready: out_valid = 0, clear both accumulators, go to ACCUM.
- Latency: out_valid rises on the 2nd rising edge after the edge that accepted sample N. Minimum batch-to-batch period is N+3 cycles, with out_ready tied high.
- Backpressure:
  - in_valid while in_ready = 0 is ignored; the sample is not consumed and the upstream must hold it.
  - out_ready is ignored outside HOLD.
- Mean always fits in DATA_WIDTH without saturation. Accumulators cannot overflow at the stated widths.
- in_valid with in_ready high on the same edge as the HOLD handshake cannot occur, because in_ready = 0 in HOLD. The first sample of the next batch is accepted one cycle later.

Optional Feature:
- Macro: BN_STATS_MIN_VAR_EN.
- Defined: in CALC_VAR, a final variance of 0 is forced to 1 after clamp and saturate. This guarantees a non-zero variance operand for BatchNorm normalisation.
- Undefined: variance 0 is emitted as 0.
- No other behaviour changes.

Test Plan:
- Defaults, 16 samples of 100, out_ready = 1 → out_mean = 100, out_variance = 0 (1 with BN_STATS_MIN_VAR_EN). out_valid high exactly 2 cycles after the 16th accept, for one cycle.
- 8 samples of 10, then 8 samples of −10 → out_mean = 0, out_variance = 100.
- Samples 0..15 → out_mean = 7 (floor of 7.5), msq = 77, out_variance = 28.
- 8 samples of 32767, then 8 samples of −32768 → out_mean = −1. Variance saturates to 32767. Then 16 samples of −1 → out_mean = −1, out_variance = 0.
- Backpressure: out_ready held low 5 cycles after out_valid, with in_valid = 1 driving 50 → out_valid, out_mean and out_variance stable; in_ready = 0; no samples counted. After out_ready goes high, the next batch starts cleanly with the first 50 accepted 1 cycle after the handshake.
- Reset low asynchronously (mid-cycle) after 7 samples of 200 → all outputs 0 immediately. A fresh batch of 16 samples of 3 → out_mean = 3, out_variance = 0, with no contamination from the aborted batch.
